// File: rtl/busif_chain_sync.sv
// JTAG debug-bus scan chain running on the SoC clock: TCK and its controls are oversampled,
// shifted commands become req/ack bus transactions, and results are captured back for the debugger.
module busif_chain_sync #(
  parameter int RADDR_WIDTH = 12,
  parameter int RDATA_WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   TCK,
  input  logic                   SEL_CHAIN,
  input  logic                   LOAD_CHAIN,
  input  logic                   STORE_CHAIN,
  input  logic                   SI,
  output logic                   SO,
  output logic [RADDR_WIDTH-1:0] addr_o,
  output logic [RDATA_WIDTH-1:0] data_o,
  input  logic [RDATA_WIDTH-1:0] data_i,
  output logic                   wr_o,
  output logic                   req_o,
  input  logic                   ack_i
);

  localparam int W  = RADDR_WIDTH + RDATA_WIDTH + 2;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, REQ} state_t;

  // Bus handshake: req_o stays high with addr_o/data_o/wr_o stable until ack_i is
  // sampled high (transfer completes on that edge) or the timeout expires.
  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] tck_sync, sel_sync, load_sync, store_sync, si_sync;
  logic                   tck_d;
  logic [W-1:0]           chain;
  logic                   so_r;
  logic                   req_r, wr_r, inc_r, err, err_clr;
  logic [RADDR_WIDTH-1:0] addr_r;
  logic [RDATA_WIDTH-1:0] wdata_r, rdata_r;
  logic [CW-1:0]          tmo_cnt;
  logic                   tck_s, sel_s, load_s, store_s, si_s;
  logic                   chain_evt, load_evt, store_evt, shift_evt;
  logic                   cmd_accept, overrun, bus_done, timed_out, busy;
  logic [1:0]             chain_op;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_sync   <= '0;
      sel_sync   <= '0;
      load_sync  <= '0;
      store_sync <= '0;
      si_sync    <= '0;
      tck_d      <= 1'b0;
    end else begin
      tck_sync   <= {tck_sync[SYNC_STAGES-2:0], TCK};
      sel_sync   <= {sel_sync[SYNC_STAGES-2:0], SEL_CHAIN};
      load_sync  <= {load_sync[SYNC_STAGES-2:0], LOAD_CHAIN};
      store_sync <= {store_sync[SYNC_STAGES-2:0], STORE_CHAIN};
      si_sync    <= {si_sync[SYNC_STAGES-2:0], SI};
      tck_d      <= tck_s;
    end
  end

  assign tck_s   = tck_sync[SYNC_STAGES-1];
  assign sel_s   = sel_sync[SYNC_STAGES-1];
  assign load_s  = load_sync[SYNC_STAGES-1];
  assign store_s = store_sync[SYNC_STAGES-1];
  assign si_s    = si_sync[SYNC_STAGES-1];

  assign chain_evt = tck_s & ~tck_d & sel_s;
  assign load_evt  = chain_evt & load_s;
  assign store_evt = chain_evt & ~load_s & store_s;
  assign shift_evt = chain_evt & ~load_s & ~store_s;
  assign chain_op  = chain[1:0];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain <= '0;
      so_r  <= 1'b0;
    end else if (load_evt) begin
      chain <= {addr_r, rdata_r, busy, err};
      so_r  <= err;
    end else if (shift_evt) begin
      chain <= {si_s, chain[W-1:1]};
      so_r  <= chain[1];
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_accept = 1'b0;
    overrun    = 1'b0;
    bus_done   = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (store_evt && chain_op != 2'b00) begin
          cmd_accept = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        overrun = store_evt;
        // Ack and timeout only count once req_o is actually visible on the bus.
        if (req_r && ack_i) begin
          bus_done  = 1'b1;
          state_nxt = IDLE;
        end else if (req_r && tmo_cnt == CW'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      req_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      wr_r    <= 1'b0;
      inc_r   <= 1'b0;
      rdata_r <= '0;
      err     <= 1'b0;
      err_clr <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      err_clr <= load_evt;
      if (overrun || timed_out) err <= 1'b1;
      else if (err_clr)         err <= 1'b0;
      if (cmd_accept) begin
        addr_r  <= chain[W-1 -: RADDR_WIDTH];
        wdata_r <= chain[RDATA_WIDTH+1:2];
        wr_r    <= chain_op[0];
        inc_r   <= &chain_op;
        tmo_cnt <= '0;
      end else if (req_r && !ack_i) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (bus_done || timed_out) req_r <= 1'b0;
      else if (state == REQ)     req_r <= 1'b1;
      if (bus_done) begin
        if (!wr_r) rdata_r <= data_i;
        if (inc_r) addr_r  <= addr_r + 1'b1;
      end
    end
  end

  assign SO     = so_r;
  assign req_o  = req_r;
  assign addr_o = addr_r;
  assign data_o = wdata_r;
  assign wr_o   = wr_r;

endmodule

// File: tb/tb_busif_chain_sync.sv
// Directed bench for busif_chain_sync: scan commands in, bus transactions and scan
// read-backs are checked by monitors against expected queues.
module tb_busif_chain_sync;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int W   = AW + DW + 2;
  localparam int LAT = 2 + 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
    int            len;
  } bus_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          tck = 1'b0, sel = 1'b0, load = 1'b0, store = 1'b0, si = 1'b0;
  logic          so;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic [DW-1:0] data_i = '0;
  logic          wr_o, req_o;
  logic          ack_i = 1'b0;

  int n_cmp = 0, n_fail = 0, n_done = 0, cyc = 0, last_rise_cyc = 0;
  bit ack_on = 1'b0;
  int ack_delay = 0, resp_cnt = 0;
  logic [DW-1:0] rd_data = '0;

  bus_t         bus_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  busif_chain_sync #(.RADDR_WIDTH(AW), .RDATA_WIDTH(DW), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_i(rst_i), .TCK(tck), .SEL_CHAIN(sel), .LOAD_CHAIN(load),
    .STORE_CHAIN(store), .SI(si), .SO(so), .addr_o(addr_o), .data_o(data_o),
    .data_i(data_i), .wr_o(wr_o), .req_o(req_o), .ack_i(ack_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [1:0] op);
    return {a, d, op};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tck_bit(input logic s, input logic l, input logic st, input logic b);
    sel = s; load = l; store = st; si = b; tck = 1'b0;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    last_rise_cyc = cyc;
    repeat (4) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic shift_in(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) tck_bit(1'b1, 1'b0, 1'b0, w[i]);
  endtask

  task automatic do_store();
    tck_bit(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic load_read();
    logic [W-1:0] got;
    tck_bit(1'b1, 1'b1, 1'b0, 1'b0);
    got[0] = so;
    for (int i = 1; i < W; i++) begin
      tck_bit(1'b1, 1'b0, 1'b0, 1'b0);
      got[i] = so;
    end
    obs_q.push_back(got);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 600 && n_done < target; i++) @(negedge clk);
    if (n_done < target) check("bus_done_timeout", 64'(n_done), 64'(target));
  endtask

  task automatic expect_bus(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic w, input int len);
    bus_t e;
    e.addr = a; e.data = d; e.wr = w; e.len = len;
    bus_q.push_back(e);
  endtask

  // Bus slave: acks ack_delay cycles after req_o is first seen, when enabled.
  always @(negedge clk) begin
    if (ack_on) begin
      ack_i = 1'b0;
      if (req_o) begin
        if (resp_cnt == ack_delay) begin
          ack_i  = 1'b1;
          data_i = rd_data;
        end
        resp_cnt++;
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard monitors ----------------
  bus_t cur;
  bit   in_req = 1'b0, have_cur = 1'b0, bad = 1'b0;
  int   cur_len = 0;

  always @(negedge clk) begin
    if (req_o && !in_req) begin
      in_req = 1'b1; cur_len = 1; bad = 1'b0;
      if (bus_q.size() == 0) begin
        have_cur = 1'b0;
        n_cmp++; n_fail++;
        $display("FAIL unexpected_req: addr 0x%0h wr %0b, no transaction expected", addr_o, wr_o);
      end else begin
        cur = bus_q.pop_front();
        have_cur = 1'b1;
        check("req_addr", 64'(addr_o), 64'(cur.addr));
        check("req_data", 64'(data_o), 64'(cur.data));
        check("req_wr", 64'(wr_o), 64'(cur.wr));
        check("req_latency", 64'(cyc - last_rise_cyc), 64'(LAT));
      end
    end else if (req_o && in_req) begin
      cur_len++;
      if (have_cur && (addr_o !== cur.addr || data_o !== cur.data || wr_o !== cur.wr)) bad = 1'b1;
    end else if (!req_o && in_req) begin
      in_req = 1'b0;
      n_done++;
      if (have_cur) begin
        check("req_len", 64'(cur_len), 64'(cur.len));
        check("req_stable", 64'(bad), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    while (obs_q.size() > 0) begin
      logic [W-1:0] got;
      got = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL scan_unexpected: got 0x%0h", got);
      end else begin
        check("scan_word", 64'(got), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (5) @(negedge clk);
    rst_i = 1'b0;
    check("rst_req", 64'(req_o), 64'd0);
    check("rst_so", 64'(so), 64'd0);
    check("rst_addr", 64'(addr_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_wr", 64'(wr_o), 64'd0);

    // 1: WRITE, ack after 3 cycles
    ack_on = 1'b1; ack_delay = 3;
    expect_bus(12'h123, 32'hDEADBEEF, 1'b1, 4);
    shift_in(mk(12'h123, 32'hDEADBEEF, 2'b01));
    do_store();
    wait_done(1);
    exp_q.push_back(mk(12'h123, 32'h0, 2'b00));
    load_read();

    // 2: READ 0x040
    ack_delay = 1; rd_data = 32'hCAFEF00D;
    expect_bus(12'h040, 32'h0, 1'b0, 2);
    shift_in(mk(12'h040, 32'h0, 2'b10));
    do_store();
    wait_done(2);
    exp_q.push_back(mk(12'h040, 32'hCAFEF00D, 2'b00));
    load_read();

    // 3: WRITE_INC wraps, NOP is silent, then WRITE_INC from 0x010
    ack_delay = 0; rd_data = 32'h0BADBAD0;
    expect_bus(12'hFFF, 32'h11111111, 1'b1, 1);
    shift_in(mk(12'hFFF, 32'h11111111, 2'b11));
    do_store();
    wait_done(3);
    exp_q.push_back(mk(12'h000, 32'hCAFEF00D, 2'b00));
    load_read();
    shift_in(mk(12'h0AA, 32'h0, 2'b00));
    do_store();
    ack_delay = 2;
    expect_bus(12'h010, 32'h22222222, 1'b1, 3);
    shift_in(mk(12'h010, 32'h22222222, 2'b11));
    do_store();
    wait_done(4);
    exp_q.push_back(mk(12'h011, 32'hCAFEF00D, 2'b00));
    load_read();

    // 4: READ with no ack -> timeout, err seen once
    ack_on = 1'b0; ack_i = 1'b0;
    expect_bus(12'h077, 32'h0, 1'b0, 255);
    shift_in(mk(12'h077, 32'h0, 2'b10));
    do_store();
    wait_done(5);
    exp_q.push_back(mk(12'h077, 32'hCAFEF00D, 2'b01));
    load_read();
    exp_q.push_back(mk(12'h077, 32'hCAFEF00D, 2'b00));
    load_read();

    // 5: STORE during REQ is dropped as overrun; LOAD during REQ shows busy+err
    ack_on = 1'b1; ack_delay = 40;
    expect_bus(12'h321, 32'h12345678, 1'b1, 41);
    shift_in(mk(12'h321, 32'h12345678, 2'b01));
    do_store();
    do_store();
    exp_q.push_back(mk(12'h321, 32'hCAFEF00D, 2'b11));
    load_read();
    wait_done(6);
    exp_q.push_back(mk(12'h321, 32'hCAFEF00D, 2'b00));
    load_read();

    // 6: reset during REQ, late ack ignored, then a normal WRITE
    ack_on = 1'b0; ack_i = 1'b0;
    expect_bus(12'h0AB, 32'h0, 1'b0, 5);
    shift_in(mk(12'h0AB, 32'h0, 2'b10));
    do_store();
    while (cyc < last_rise_cyc + 8) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_rst_req", 64'(req_o), 64'd0);
    check("mid_rst_addr", 64'(addr_o), 64'd0);
    check("mid_rst_wr", 64'(wr_o), 64'd0);
    @(negedge clk);
    ack_i = 1'b1; data_i = 32'h55555555;
    @(negedge clk);
    ack_i = 1'b0;
    check("post_ack_req", 64'(req_o), 64'd0);
    exp_q.push_back(mk(12'h000, 32'h0, 2'b00));
    load_read();
    ack_on = 1'b1; ack_delay = 2;
    expect_bus(12'h5A5, 32'h0F0F0F0F, 1'b1, 3);
    shift_in(mk(12'h5A5, 32'h0F0F0F0F, 2'b01));
    do_store();
    wait_done(8);
    exp_q.push_back(mk(12'h5A5, 32'h0, 2'b00));
    load_read();

    repeat (20) @(negedge clk);
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    n_cmp++; n_fail++;
    $display("FAIL watchdog: run did not complete within 60000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/busif_chain_sync.md
Name: busif_chain_sync

Overview:
JTAG debug-bus scan chain, second generation. Runs entirely on the SoC clock and oversamples TCK, so no async FIFOs are needed. Shifts an [address|data|op] word in from the TAP and executes read/write transactions on a req/ack bus master port. Captures back the address, read data and status for the debugger. Sits between the TAP controller and the system debug module.

Parameters:
RADDR_WIDTH, 12, bus address width
RDATA_WIDTH, 32, bus data width
SYNC_STAGES, 2, synchroniser depth for all TAP-side inputs (>=2)
TIMEOUT, 255, clk_i cycles to wait for ack_i before aborting (>=1)

Ports:
clk_i  in  1  SoC clock; the only clock
rst_i  in  1  synchronous active-high reset
TCK  in  1  JTAG clock, sampled as data
SEL_CHAIN  in  1  chain selected (TCK domain)
LOAD_CHAIN  in  1  capture request (TCK domain)
STORE_CHAIN  in  1  update request (TCK domain)
SI  in  1  serial in
SO  out  1  serial out
addr_o  out  RADDR_WIDTH  bus address
data_o  out  RDATA_WIDTH  bus write data
data_i  in  RDATA_WIDTH  bus read data, valid with ack_i
wr_o  out  1  1=write, 0=read; valid while req_o
req_o  out  1  bus request
ack_i  in  1  bus acknowledge

Behaviour:
- Sync: TCK, SEL_CHAIN, LOAD_CHAIN, STORE_CHAIN and SI each pass through SYNC_STAGES flops. A TCK event is a 0->1 transition of the synchronised TCK. All chain actions use the synchronised control and SI values on the event cycle. TCK high and low phases must each be >= 2 clk_i periods.
- Chain layout, W = RADDR_WIDTH+RDATA_WIDTH+2: [W-1:RDATA_WIDTH+2] addr, [RDATA_WIDTH+1:2] data, [1:0] op/status.
- On a TCK event with SEL_CHAIN=1, priority is LOAD > STORE > shift:
  - LOAD: chain <= {addr_r, rdata_r, busy, err}. busy = FSM not IDLE. After the capture, err is cleared on the next clk_i.
  - STORE: decode chain op as 00 NOP, 01 WRITE, 10 READ, 11 WRITE_INC.
  - shift: chain <= {SI, chain[W-1:1]}.
- SEL_CHAIN=0: chain holds.
- SO = chain[0], registered. It changes only on a TCK event.
- FSM states: IDLE, REQ.
  - IDLE + STORE, op != NOP: addr_r <= chain addr, wdata_r <= chain data, wr_r <= op[0]. Go to REQ. req_o=1 from the next cycle.
  - IDLE + STORE, op = NOP: no bus activity, state unchanged.
  - REQ + STORE: command dropped and err <= 1 (overrun). The in-flight transaction is unaffected.
  - REQ, ack_i=1: req_o deasserts on the next cycle and the FSM returns to IDLE.
    - Read: rdata_r <= data_i.
    - WRITE_INC: addr_r <= addr_r+1 modulo 2^RADDR_WIDTH, so all-ones wraps to 0.
  - REQ, no ack for TIMEOUT consecutive cycles: req_o drops, err <= 1, back to IDLE, rdata_r unchanged, no increment.
  - ack_i in IDLE: ignored.
- addr_o=addr_r, data_o=wdata_r, wr_o=wr_r. These are stable for the entire time req_o is high.
- err is set and cleared on the same cycle: set wins.
- Latency: req_o rises SYNC_STAGES+2 clk_i cycles after the TCK rising edge that performs STORE.
- Reset, values on the cycle after rst_i: req_o=0, SO=0, addr_o=0, data_o=0, wr_o=0, chain=0, rdata_r=0, err=0, FSM=IDLE, sync flops=0, timeout counter=0. A transaction in flight at reset is abandoned; its late ack_i is ignored.

Test Plan:
1. Shift {addr 0x123, data 0xDEADBEEF, op 01}, STORE, ack after 3 cycles -> req_o=1, wr_o=1, addr_o=0x123, data_o=0xDEADBEEF until ack; req_o=0 the cycle after ack. LOAD then shift out yields addr 0x123, status 00.
2. READ of 0x040 with data_i=0xCAFEF00D at ack -> LOAD/shift returns data 0xCAFEF00D, addr 0x040, status 00.
3. WRITE_INC at addr 0xFFF, ack -> a later LOAD returns addr 0x000; a second WRITE_INC (NOP shift, STORE, op 11 with new addr 0x010) increments to 0x011.
4. READ with ack_i held 0 -> req_o drops after exactly 255 cycles. LOAD returns status 01. A second LOAD returns status 00, since err cleared after the first capture.
5. STORE issued while REQ (ack withheld) -> no second req pulse, addr_o unchanged. LOAD during REQ returns status 11.
6. rst_i pulse during REQ, ack_i asserted 2 cycles later -> req_o=0 from the cycle after reset, rdata_r stays 0, FSM IDLE. The next STORE WRITE operates normally.
